// File: rtl/bpu_pkg.sv
// Shared types and width helpers for the gshare branch predictor.
// Holds the 2-bit counter encodings and the BTB index/tag width calculations.
package bpu_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  localparam ctr_e CTR_RESET = WNT;

  function automatic int btb_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // Tag covers every PC bit above the word offset and the BTB index.
  function automatic int btb_tag_w(input int pc_w, input int entries);
    return pc_w - 2 - $clog2(entries);
  endfunction

endpackage

// File: rtl/branch_predictor_gshare_sat_counter2.sv
// 2-bit saturating counter next-state function used on every PHT write.
module sat_counter2
  import bpu_pkg::*;
(
  input  ctr_e cur,
  input  logic taken,
  output ctr_e nxt
);

  // Step toward ST on taken, toward SNT on not-taken, holding at the ends.
  always_comb begin
    nxt = CTR_RESET;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = CTR_RESET;
    endcase
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// gshare direction predictor with a direct-mapped tagged BTB and resolve-time redirect.
// Optional BPU_STATS_EN adds saturating branch / mispredict counters.
module branch_predictor_gshare
  import bpu_pkg::*;
#(
  parameter int PC_W        = 12,
  parameter int BTB_ENTRIES = 16,
  parameter int GHR_W       = 4,
  parameter int PHT_IDX_W   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_W-1:0]      pc_in,
  output logic                 predict_taken,
  output logic                 btb_hit,
  output logic [PC_W-1:0]      predict_target,
  output logic [PHT_IDX_W-1:0] pred_idx,
  input  logic                 upd_valid,
  input  logic                 upd_is_branch,
  input  logic [PC_W-1:0]      upd_pc,
  input  logic [PHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken,
  input  logic [PC_W-1:0]      upd_target,
  input  logic                 upd_pred_taken,
  input  logic                 upd_btb_hit,
  output logic                 mispredict,
  output logic [PC_W-1:0]      redirect_pc
`ifdef BPU_STATS_EN
  ,
  output logic [15:0]          stat_branches,
  output logic [15:0]          stat_mispredicts
`endif
);

  localparam int BTB_IDX_W = btb_idx_w(BTB_ENTRIES);
  localparam int TAG_W     = btb_tag_w(PC_W, BTB_ENTRIES);
  localparam int PHT_DEPTH = 1 << PHT_IDX_W;

  logic                 btb_valid_r  [BTB_ENTRIES];
  logic [TAG_W-1:0]     btb_tag_r    [BTB_ENTRIES];
  logic [PC_W-1:0]      btb_target_r [BTB_ENTRIES];
  ctr_e                 pht_r        [PHT_DEPTH];
  logic [GHR_W-1:0]     ghr_r;

  logic [BTB_IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0]     lk_tag_s;
  logic                 lk_hit_s;
  logic [PHT_IDX_W-1:0] ghr_ext_s;
  logic [BTB_IDX_W-1:0] upd_bidx_s;
  logic [TAG_W-1:0]     upd_tag_s;
  logic                 upd_fire_s;
  ctr_e                 pht_next_s;
  logic [GHR_W-1:0]     ghr_next_s;
  logic                 unused_pc_bits_s;

  assign lk_idx_s         = pc_in[2 +: BTB_IDX_W];
  assign lk_tag_s         = pc_in[PC_W-1 -: TAG_W];
  assign upd_bidx_s       = upd_pc[2 +: BTB_IDX_W];
  assign upd_tag_s        = upd_pc[PC_W-1 -: TAG_W];
  assign upd_fire_s       = upd_valid && upd_is_branch;
  assign unused_pc_bits_s = ^pc_in[1:0];

  // Fetch-side lookup: history-hashed PHT index and BTB hit/target.
  always_comb begin
    ghr_ext_s                = {PHT_IDX_W{1'b0}};
    ghr_ext_s[GHR_W-1:0]     = ghr_r;
    pred_idx                 = pc_in[2 +: PHT_IDX_W] ^ ghr_ext_s;
    lk_hit_s                 = btb_valid_r[lk_idx_s] && (btb_tag_r[lk_idx_s] == lk_tag_s);
    btb_hit                  = lk_hit_s;
    predict_target           = lk_hit_s ? btb_target_r[lk_idx_s] : {PC_W{1'b0}};
    predict_taken            = lk_hit_s && ((pht_r[pred_idx] == WT) || (pht_r[pred_idx] == ST));
  end

  // Resolve-side decision: direction wrong, taken without a BTB entry, or stale target.
  always_comb begin
    if (upd_fire_s) begin
      mispredict = (upd_taken != upd_pred_taken)
                || (upd_taken && !upd_btb_hit)
                || (upd_taken && (btb_target_r[upd_bidx_s] != upd_target));
    end else begin
      mispredict = 1'b0;
    end
    redirect_pc = upd_taken ? upd_target : (upd_pc + {{(PC_W-3){1'b0}}, 3'd4});
    ghr_next_s  = (ghr_r << 1) | {{(GHR_W-1){1'b0}}, upd_taken};
  end

  sat_counter2 u_pht_ctr (
    .cur   (pht_r[upd_idx]),
    .taken (upd_taken),
    .nxt   (pht_next_s)
  );

  // PHT counter write at resolution.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PHT_DEPTH; i++) pht_r[i] <= CTR_RESET;
    end else if (upd_fire_s) begin
      pht_r[upd_idx] <= pht_next_s;
    end
  end

  // Committed global history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_r <= {GHR_W{1'b0}};
    end else if (upd_fire_s) begin
      ghr_r <= ghr_next_s;
    end
  end

  // BTB allocation: only taken branches write, overwriting whatever occupies the slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_r[i]  <= 1'b0;
        btb_tag_r[i]    <= {TAG_W{1'b0}};
        btb_target_r[i] <= {PC_W{1'b0}};
      end
    end else if (upd_fire_s && upd_taken) begin
      btb_valid_r[upd_bidx_s]  <= 1'b1;
      btb_tag_r[upd_bidx_s]    <= upd_tag_s;
      btb_target_r[upd_bidx_s] <= upd_target;
    end
  end

`ifdef BPU_STATS_EN
  // Saturating branch and mispredict event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches    <= 16'd0;
      stat_mispredicts <= 16'd0;
    end else if (upd_fire_s) begin
      if (stat_branches != 16'hFFFF) stat_branches <= stat_branches + 16'd1;
      if (mispredict && (stat_mispredicts != 16'hFFFF)) stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Self-checking bench: directed scenarios plus random traffic against an array-based model.
module tb_branch_predictor_gshare;

  logic        clk;
  logic        reset;
  logic [11:0] pc_in;
  logic        predict_taken, btb_hit, mispredict;
  logic [11:0] predict_target, redirect_pc;
  logic [5:0]  pred_idx;
  logic        upd_valid, upd_is_branch, upd_taken, upd_pred_taken, upd_btb_hit;
  logic [11:0] upd_pc, upd_target;
  logic [5:0]  upd_idx;
`ifdef BPU_STATS_EN
  logic [15:0] stat_branches, stat_mispredicts;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference state: counters as integers 0..3, history as an integer, BTB as plain arrays.
  int pht_m [64];
  int ghr_m;
  bit bv_m [16];
  int btag_m [16];
  int btgt_m [16];
  int sb_m, sm_m;

  branch_predictor_gshare dut (
    .clk(clk), .reset(reset), .pc_in(pc_in),
    .predict_taken(predict_taken), .btb_hit(btb_hit),
    .predict_target(predict_target), .pred_idx(pred_idx),
    .upd_valid(upd_valid), .upd_is_branch(upd_is_branch), .upd_pc(upd_pc),
    .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_btb_hit(upd_btb_hit),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BPU_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) pht_m[i] = 1;
    for (int i = 0; i < 16; i++) begin
      bv_m[i] = 1'b0; btag_m[i] = 0; btgt_m[i] = 0;
    end
    ghr_m = 0; sb_m = 0; sm_m = 0;
  endtask

  function automatic bit model_hit(input int pc);
    return bv_m[(pc / 4) % 16] && (btag_m[(pc / 4) % 16] == pc / 64);
  endfunction

  task automatic set_upd(input logic v, input logic br, input logic [11:0] pc, input logic [5:0] idx,
                         input logic t, input logic [11:0] tgt, input logic pt, input logic bh);
    upd_valid = v; upd_is_branch = br; upd_pc = pc; upd_idx = idx;
    upd_taken = t; upd_target = tgt; upd_pred_taken = pt; upd_btb_hit = bh;
  endtask

  // Called just after a negedge with inputs applied; checks, clocks, advances the model.
  task automatic do_cycle();
    int  bi, pi, ub, c;
    bit  hit, fire, exp_mis;
    #1;
    bi  = (int'(pc_in) / 4) % 16;
    hit = model_hit(int'(pc_in));
    pi  = ((int'(pc_in) / 4) % 64) ^ ghr_m;
    check_eq("btb_hit", btb_hit, hit);
    check_eq("predict_target", predict_target, hit ? btgt_m[bi] : 0);
    check_eq("predict_taken", predict_taken, hit && (pht_m[pi] >= 2));
    check_eq("pred_idx", pred_idx, pi);
    fire    = upd_valid && upd_is_branch;
    ub      = (int'(upd_pc) / 4) % 16;
    exp_mis = fire && ((upd_taken != upd_pred_taken) || (upd_taken && !upd_btb_hit)
                       || (upd_taken && (btgt_m[ub] != int'(upd_target))));
    check_eq("mispredict", mispredict, exp_mis);
    if (fire)
      check_eq("redirect_pc", redirect_pc, upd_taken ? int'(upd_target) : (int'(upd_pc) + 4) % 4096);
    @(posedge clk);
    if (fire) begin
      c = pht_m[upd_idx];
      pht_m[upd_idx] = upd_taken ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
      ghr_m = (ghr_m * 2 + int'(upd_taken)) % 16;
      if (upd_taken) begin
        bv_m[ub] = 1'b1; btag_m[ub] = int'(upd_pc) / 64; btgt_m[ub] = int'(upd_target);
      end
      if (sb_m < 65535) sb_m++;
      if (exp_mis && sm_m < 65535) sm_m++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #3;
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int sel;
    reset = 1'b1; pc_in = 12'h000;
    set_upd(1'b0, 1'b0, 12'h000, 6'd0, 1'b0, 12'h000, 1'b0, 1'b0);
    @(negedge clk);
    do_reset();

    // Cold lookup.
    pc_in = 12'h010;
    #1 check_eq("cold_hit", btb_hit, 1'b0);
    check_eq("cold_target", predict_target, 12'h000);
    do_cycle();

    // First taken branch allocates and redirects.
    set_upd(1'b1, 1'b1, 12'h010, 6'd4, 1'b1, 12'h100, 1'b0, 1'b0);
    #1 check_eq("alloc_misp", mispredict, 1'b1);
    check_eq("alloc_redirect", redirect_pc, 12'h100);
    do_cycle();
    set_upd(1'b0, 1'b0, 12'h000, 6'd0, 1'b0, 12'h000, 1'b0, 1'b0);
    #1 check_eq("alloc_hit", btb_hit, 1'b1);
    check_eq("alloc_target", predict_target, 12'h100);
    do_cycle();

    // Saturate one counter up, then down.
    for (int k = 0; k < 8; k++) begin
      set_upd(1'b1, 1'b1, 12'h010, 6'd4, k < 4, 12'h100, k < 4, 1'b1);
      do_cycle();
    end

    // Not-taken at top of address space, then wrapped fall-through.
    set_upd(1'b1, 1'b1, 12'hFFC, 6'd3, 1'b0, 12'h000, 1'b0, 1'b0);
    #1 check_eq("nt_ok_misp", mispredict, 1'b0);
    do_cycle();
    set_upd(1'b1, 1'b1, 12'hFFC, 6'd3, 1'b0, 12'h000, 1'b1, 1'b0);
    #1 check_eq("nt_wrong_misp", mispredict, 1'b1);
    check_eq("wrap_redirect", redirect_pc, 12'h000);
    do_cycle();

    // Non-branch resolution never flags.
    set_upd(1'b1, 1'b0, 12'h010, 6'd4, 1'b1, 12'h300, 1'b0, 1'b0);
    #1 check_eq("nonbranch_misp", mispredict, 1'b0);
    do_cycle();

    // Aliasing: 0x050 evicts 0x010 from the same slot.
    set_upd(1'b1, 1'b1, 12'h050, 6'd20, 1'b1, 12'h300, 1'b1, 1'b0);
    do_cycle();
    set_upd(1'b0, 1'b0, 12'h000, 6'd0, 1'b0, 12'h000, 1'b0, 1'b0);
    #1 check_eq("alias_hit", btb_hit, 1'b0);
    do_cycle();
    set_upd(1'b1, 1'b1, 12'h050, 6'd20, 1'b1, 12'h200, 1'b1, 1'b1);
    #1 check_eq("stale_target_misp", mispredict, 1'b1);
    do_cycle();

    // Mid-cycle asynchronous reset clears the BTB immediately.
    pc_in = 12'h050;
    set_upd(1'b0, 1'b0, 12'h000, 6'd0, 1'b0, 12'h000, 1'b0, 1'b0);
    #2 reset = 1'b0;
    model_reset();
    #1 check_eq("rst_hit", btb_hit, 1'b0);
    check_eq("rst_pred_idx", pred_idx, 6'd20);
    #1 reset = 1'b1;
    @(negedge clk);

    // History T,N,T,T from a clean reset.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_upd(1'b1, 1'b1, 12'h040, 6'd7, k != 1, 12'h080, 1'b0, 1'b0);
      do_cycle();
    end
    pc_in = 12'h000;
    set_upd(1'b0, 1'b0, 12'h000, 6'd0, 1'b0, 12'h000, 1'b0, 1'b0);
    #1 check_eq("ghr_pred_idx", pred_idx, 6'b001011);
`ifdef BPU_STATS_EN
    check_eq("stat_branches4", stat_branches, 16'd4);
    check_eq("stat_misp", stat_mispredicts, sm_m);
`endif
    do_cycle();

    // Random traffic over a small PC pool so hits, aliases and stale targets recur.
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: pc_in = 12'h010;
        1: pc_in = 12'h050;
        2: pc_in = 12'hFFC;
        default: pc_in = 12'($urandom_range(0, 31) * 4);
      endcase
      upd_valid      = ($urandom_range(0, 3) != 0);
      upd_is_branch  = ($urandom_range(0, 4) != 0);
      upd_pc         = ($urandom_range(0, 3) == 0) ? 12'hFFC : 12'($urandom_range(0, 31) * 4);
      upd_idx        = 6'($urandom_range(0, 63));
      upd_taken      = 1'($urandom_range(0, 1));
      upd_target     = 12'($urandom_range(0, 7) * 4);
      upd_pred_taken = 1'($urandom_range(0, 1));
      upd_btb_hit    = model_hit(int'(upd_pc)) ^ ($urandom_range(0, 7) == 0);
      do_cycle();
    end
    set_upd(1'b0, 1'b0, 12'h000, 6'd0, 1'b0, 12'h000, 1'b0, 1'b0);
`ifdef BPU_STATS_EN
    #1 check_eq("stat_branches", stat_branches, sb_m);
    check_eq("stat_mispredicts", stat_mispredicts, sm_m);
`endif
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
Parametrised successor to the core's fixed 12-bit bimodal BPU. Provides a gshare direction predictor: a PHT of 2-bit counters indexed by PC XOR global history, plus a direct-mapped tagged BTB. Lookup is combinational from the IF-stage PC. Update is registered from the resolving stage (EX/MEM). The block also generates the mispredict/redirect decision that drives flush_branch.

Parameters:
PC_W, 12, PC/target width in bits.
BTB_ENTRIES, 16, BTB depth; power of two, minimum 2.
GHR_W, 4, global history length in bits.
PHT_IDX_W, 6, PHT index width (PHT depth = 2**PHT_IDX_W); must be >= GHR_W.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
pc_in  in  PC_W  IF-stage fetch PC
predict_taken  out  1  predicted taken; already qualified by btb_hit
btb_hit  out  1  BTB valid and tag match for pc_in
predict_target  out  PC_W  BTB target; 0 when no hit
pred_idx  out  PHT_IDX_W  PHT index used for this lookup; carried down the pipe
upd_valid  in  1  one-cycle pulse, resolved instruction present
upd_is_branch  in  1  resolved instruction is a conditional branch
upd_pc  in  PC_W  PC of the resolved branch
upd_idx  in  PHT_IDX_W  pred_idx captured at that branch's fetch
upd_taken  in  1  actual outcome
upd_target  in  PC_W  actual taken target
upd_pred_taken  in  1  prediction made at fetch
upd_btb_hit  in  1  BTB hit at fetch
mispredict  out  1  combinational; flush request
redirect_pc  out  PC_W  correct next PC when mispredict=1

Behaviour:
- Word-aligned PCs. BTB index = pc[2 +: log2(BTB_ENTRIES)]. BTB tag = all PC bits above the index.
- pred_idx = pc_in[2 +: PHT_IDX_W] XOR {zero-extend(ghr)}.
- btb_hit = valid[i] && tag[i]==tag(pc_in).
- predict_taken = btb_hit && pht[pred_idx][1].
- predict_target = btb_hit ? target[i] : 0.
- mispredict is asserted when upd_valid && upd_is_branch and any of the following holds:
  - upd_taken != upd_pred_taken
  - upd_taken && !upd_btb_hit
  - upd_taken && the stored target != upd_target
- Otherwise mispredict = 0.
- redirect_pc = upd_taken ? upd_target : upd_pc+4. Addition is modulo 2**PC_W (wraps).
- Update fires on the clock edge when upd_valid && upd_is_branch. All sequential state updates at posedge clk:
  - PHT[upd_idx] saturating counter: +1 if taken (saturate at 3), -1 if not taken (saturate at 0).
  - GHR <= {ghr[GHR_W-2:0], upd_taken}. History is non-speculative, committed at resolution.
  - BTB: on a taken branch, write valid=1, tag and target at upd_pc's index, overwriting any occupant. A not-taken branch never allocates and never invalidates.
- upd_valid with !upd_is_branch: no state change, mispredict=0.
- Same-cycle lookup and update of the same entry: lookup returns the pre-update value (write-then-visible next cycle).
- No back-pressure. Stalls are the caller's concern; the caller must present each resolution exactly once.
- Reset (asynchronous, active-low, may assert mid-operation) clears the following immediately:
  - every BTB valid to 0; tags/targets to 0
  - every PHT counter to 2'b01 (weakly not-taken)
  - GHR to 0
  - all outputs then read predict_taken=0, btb_hit=0, predict_target=0, pred_idx=pc_in[2 +: PHT_IDX_W], mispredict follows the upd_* inputs combinationally.

Optional Feature:
BPU_STATS_EN. When defined, adds outputs stat_branches[15:0] and stat_mispredicts[15:0].
- stat_branches increments on every branch update.
- stat_mispredicts increments when mispredict=1.
- Both saturate at 16'hFFFF and reset to 0.
When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package bpu_pkg holds:
  - localparam helpers for BTB index width and tag width, via clog2
  - counter encodings: SNT=0, WNT=1, WT=2, ST=3
  - the counter reset value WNT
- One natural sub-module: sat_counter2, a 2-bit saturating next-state function, instantiated or called per PHT write.

Test Plan:
- Reset, then pc_in=0x010: btb_hit=0, predict_taken=0, predict_target=0. Pulse reset low mid-run: all BTB valids clear within the same cycle.
- Taken branch update, upd_pc=0x010, target 0x100, pred_taken=0, btb_hit=0 -> mispredict=1, redirect_pc=0x100. Next cycle with pc_in=0x010: btb_hit=1, predict_target=0x100.
- Four consecutive taken updates at one upd_idx -> counter 01→10→11→11 (saturates). Four not-taken updates -> 11→10→01→00→00. predict_taken follows bit1.
- Not-taken branch predicted not-taken, upd_pc=0xFFC -> mispredict=0. With upd_pred_taken=1 -> mispredict=1, redirect_pc=0x000 (wrap).
- BTB aliasing, BTB_ENTRIES=16: allocate 0x010 then taken 0x050 (same index, different tag) -> lookup 0x010 gives btb_hit=0. Taken branch with matching hit but target 0x200 vs stored 0x100 -> mispredict=1.
- GHR: updates T,N,T,T with GHR_W=4 -> ghr=4'b1011, and pred_idx for pc_in=0x000 equals 6'b001011. With BPU_STATS_EN: stat_branches=4 and stat_mispredicts matches the count of flagged cycles.
